m_mem_bridge: RTL and testbench

//  Memory-side bridge between the multi-cycle CPU core and a variable-latency word RAM.

---
 rtl/m_mem_bridge_if.sv | 29 ++
 rtl/m_mem_bridge.sv | 158 +++++++++++++++
 tb/tb_m_mem_bridge.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/m_mem_bridge_if.sv
// CPU-side request/response and RAM-side strobe/acknowledge signals of the memory bridge.
// The bridge connects through the slave modport; the CPU core and RAM side use master.
interface m_mem_bridge_if #(
  parameter int ADDR_W = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              bus_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, bus_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, bus_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/m_mem_bridge.sv
// Single-outstanding bridge from the multi-cycle CPU core to a variable-latency word RAM.
// Optional WAIT timeout with bus_err reporting is built when M_MEM_BRIDGE_TIMEOUT_EN is defined.
module m_mem_bridge #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           reset,
  m_mem_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            next_state;

  logic              accept;
  logic              in_range;
  logic              timeout_hit;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              mem_en_d;
  logic              mem_we_d;
  logic              ready_d;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              ready_q;

  // Anything above the RAM's byte range completes immediately without a RAM access.
  assign in_range = (bus.cpu_addr >> (ADDR_W + 2)) == 32'd0;
  assign accept   = (state == S_IDLE) && bus.cpu_req;

`ifdef M_MEM_BRIDGE_TIMEOUT_EN
  localparam int             CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             err_d;
  logic             bus_err_q;

  // An ack on the final allowed WAIT cycle takes priority over the timeout.
  assign timeout_hit = (state == S_WAIT) && !bus.mem_ack && (wait_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (accept)               err_q <= 1'b0;
      else if (timeout_hit)     err_q <= 1'b1;
    end
  end

  assign err_d = (state == S_DONE) && err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus_err_q <= 1'b0;
    else        bus_err_q <= err_d;
  end

  assign bus.bus_err = bus_err_q;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign bus.bus_err    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first keeps this block latch-free.
    next_state = state;
    unique case (state)
      S_IDLE:  if (bus.cpu_req) next_state = in_range ? S_ISSUE : S_DONE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (bus.mem_ack || timeout_hit) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
    endcase
  end

  // Request capture and read-data return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.cpu_we;
        addr_q  <= bus.cpu_addr[ADDR_W+1:2];
        wdata_q <= bus.cpu_wdata;
        if (!in_range && !bus.cpu_we) rdata_q <= '0;
      end
      // Writes leave the last read value visible to the core.
      if (state == S_WAIT && !we_q) begin
        if (bus.mem_ack)      rdata_q <= bus.mem_rdata;
        else if (timeout_hit) rdata_q <= '0;
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    mem_en_d = 1'b0;
    mem_we_d = 1'b0;
    ready_d  = 1'b0;
    unique case (state)
      S_ISSUE: begin
        mem_en_d = 1'b1;
        mem_we_d = we_q;
      end
      S_DONE:  ready_d = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs; async reset drops strobes immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_m_mem_bridge.sv
// Self-checking bench for m_mem_bridge: directed scenarios then random traffic against a
// transaction-level model of the RAM contents, read-data register and completion latency.
module tb_m_mem_bridge;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;
  localparam int WORDS   = 1 << ADDR_W;
`ifdef M_MEM_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  m_mem_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  m_mem_bridge #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ram     [WORDS];  // stands in for the external RAM
  logic [31:0] ref_mem [WORDS];  // expected RAM contents, updated per transaction
  logic [31:0] ref_rdata;        // expected cpu_rdata

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " mem_en"},    bus.mem_en,    0);
    check({tag, " mem_we"},    bus.mem_we,    0);
    check({tag, " cpu_ready"}, bus.cpu_ready, 0);
    check({tag, " bus_err"},   bus.bus_err,   0);
    check({tag, " cpu_rdata"}, bus.cpu_rdata, 0);
    check({tag, " mem_addr"},  32'(bus.mem_addr), 0);
    check({tag, " mem_wdata"}, bus.mem_wdata, 0);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    int act = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.mem_en === 1'b1 || bus.cpu_ready === 1'b1) act++;
    end
    check({tag, " activity"}, act, 0);
  endtask

  // One CPU access. n = WAIT cycle (counted from the mem_en cycle) on which the RAM acks;
  // n = 0 means the RAM never acks. hold keeps cpu_req high after cpu_ready.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int n, input bit hold, input string tag);
    int                k = 0, en_cnt = 0, en_k = 0, lat = 0, exp_lat, word;
    bit                in_range, acked = 0;
    logic              exp_err = 1'b0, c_we = 1'b0, got_err = 1'b0;
    logic [ADDR_W-1:0] c_addr = '0;
    logic [31:0]       c_wdata = '0, got_rdata = '0;

    in_range = ((addr >> (ADDR_W + 2)) == 32'd0);
    word     = int'(addr[ADDR_W+1:2]);
    if (!in_range) begin
      exp_lat = 1;
      if (!we) ref_rdata = 32'h0;
    end else if (TO_EN && (n == 0 || n > TIMEOUT)) begin
      exp_lat = TIMEOUT + 2;
      exp_err = 1'b1;
      if (!we) ref_rdata = 32'h0;
    end else begin
      exp_lat = n + 2;
      if (we) ref_mem[word] = wdata;
      else    ref_rdata = ref_mem[word];
    end

    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.mem_ack   = 1'($urandom_range(0, 1));  // stray ack while IDLE
    bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.mem_ack   = 1'($urandom_range(0, 1));  // stray ack during ISSUE / short-path DONE
    bus.mem_rdata = $urandom;

    while (lat == 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
      if (bus.mem_en === 1'b1) begin
        en_cnt++;
        en_k    = k;
        c_addr  = bus.mem_addr;
        c_we    = bus.mem_we;
        c_wdata = bus.mem_wdata;
      end
      if (bus.cpu_ready === 1'b1) begin
        lat       = k;
        got_rdata = bus.cpu_rdata;
        got_err   = bus.bus_err;
        if (!hold) bus.cpu_req = 1'b0;
      end else if (en_k > 0 && !acked && n > 0 && k == en_k + n - 1) begin
        bus.mem_ack = 1'b1;
        if (c_we) ram[c_addr] = c_wdata;
        else      bus.mem_rdata = ram[c_addr];
        acked = 1;
      end
    end

    check({tag, " latency"},  lat, exp_lat);
    check({tag, " mem_en count"}, en_cnt, in_range ? 1 : 0);
    if (in_range) begin
      check({tag, " mem_addr"}, 32'(c_addr), 32'(addr[ADDR_W+1:2]));
      check({tag, " mem_we"},   c_we, we);
      if (we) check({tag, " mem_wdata"}, c_wdata, wdata);
    end
    check({tag, " cpu_rdata"}, got_rdata, ref_rdata);
    check({tag, " bus_err"},   got_err, exp_err);

    if (!hold) begin
      @(posedge clk); #1;
      check({tag, " ready pulse"}, bus.cpu_ready, 0);
      check({tag, " quiet after"}, bus.mem_en, 0);
    end
  endtask

  logic [31:0] r_addr;
  logic        r_we;
  int          r_n;
  bit          r_hold;

  initial begin
    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    ref_rdata     = 32'h0;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[4]     = 32'h1234_5678;
    ref_mem[4] = 32'h1234_5678;

    #2;
    check_outputs_zero("in reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle_cycles(4, "idle after reset");

    // Directed accesses.
    do_txn(1'b0, 32'h0000_0010, 32'h0,         1, 1'b0, "rd_0x10");
    do_txn(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4, 1'b0, "wr_0x20");
    do_txn(1'b0, 32'h0000_0020, 32'h0,         2, 1'b0, "rd_back_0x20");
    do_txn(1'b0, 32'h0001_0000, 32'h0,         1, 1'b0, "rd_oor");
    do_txn(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 1, 1'b0, "wr_oor");
    do_txn(1'b0, 32'h0000_0004, 32'h0,         3, 1'b0, "rd_after_oor_wr");
    do_txn(1'b0, 32'h0000_0023, 32'h0,         1, 1'b0, "rd_unaligned");
    do_txn(1'b1, 32'h0000_0FFC, 32'h5A5A_A5A5, 2, 1'b0, "wr_top_word");
    do_txn(1'b0, 32'h0000_0FFC, 32'h0,         1, 1'b0, "rd_top_word");
    do_txn(1'b0, 32'h0000_1000, 32'h0,         1, 1'b0, "rd_first_oor");

`ifdef M_MEM_BRIDGE_TIMEOUT_EN
    do_txn(1'b0, 32'h0000_0050, 32'h0,         0,       1'b0, "to_rd_noack");
    do_txn(1'b0, 32'h0000_0054, 32'h0,         TIMEOUT, 1'b0, "to_rd_ack_last");
    do_txn(1'b1, 32'h0000_0058, 32'h0BAD_F00D, 0,       1'b0, "to_wr_noack");
`endif

    // Back-to-back: cpu_req left high through cpu_ready.
    do_txn(1'b0, 32'h0000_0030, 32'h0,         1, 1'b1, "b2b_first");
    do_txn(1'b1, 32'h0000_0034, 32'h7777_1111, 2, 1'b0, "b2b_second");

    // Reset while the RAM strobe is up (state WAIT), then a late ack.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_0044;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_wait mem_en before", bus.mem_en, 1);
    #2 reset = 1'b0;
    #1;
    check_outputs_zero("rst_wait");
    ref_rdata     = 32'h0;
    bus.cpu_req   = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    idle_cycles(4, "after late ack");
    check("after late ack cpu_rdata", bus.cpu_rdata, ref_rdata);

    // Reset while cpu_ready is high.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0002_0000;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    check("rst_ready ready before", bus.cpu_ready, 1);
    #2 reset = 1'b0;
    #1;
    check("rst_ready ready dropped", bus.cpu_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(3, "after rst_ready");

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        r_addr = $urandom;
        if ((r_addr >> (ADDR_W + 2)) == 32'd0) r_addr[31] = 1'b1;
      end else begin
        r_addr = {20'h0, 12'($urandom)};
      end
      r_n    = $urandom_range(1, 6);
      r_hold = ($urandom_range(0, 3) == 0) && (i != 39);
      do_txn(r_we, r_addr, $urandom, r_n, r_hold, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
